// File: rtl/triangle_rasterizer.sv
// Scan-converts one screen-space triangle at a time into covered pixel coordinates.
// Walks the bounding box row-major, evaluating three edge functions per cycle.
module triangle_rasterizer #(
    parameter int WOI   = 12,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [1:0][WOI-1:0]      V1,
    input  logic [1:0][WOI-1:0]      V2,
    input  logic [1:0][WOI-1:0]      V3,
    input  logic                     clip,
    input  logic                     tri_valid,
    output logic                     tri_ready,
    output logic [WOI-1:0]           pix_x,
    output logic [WOI-1:0]           pix_y,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     done
);
    localparam int DW = WOI + 1;
    localparam int EW = 2 * DW + 1;
    localparam logic [WOI-1:0] XLIM = WOI'(SCR_W - 1);
    localparam logic [WOI-1:0] YLIM = WOI'(SCR_H - 1);

    typedef logic [1:0][WOI-1:0] vtx_t;
    typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;

    state_t         state;
    vtx_t           v1_q, v2_q, v3_q;
    logic [WOI-1:0] xmin, xmax, ymax, cx, cy;

    function automatic logic signed [EW-1:0] edge_fn(input vtx_t a, input vtx_t b, input vtx_t p);
        logic signed [DW-1:0] dx_ab, dy_ab, dx_ap, dy_ap;
        dx_ab = $signed({1'b0, b[0]}) - $signed({1'b0, a[0]});
        dy_ab = $signed({1'b0, b[1]}) - $signed({1'b0, a[1]});
        dx_ap = $signed({1'b0, p[0]}) - $signed({1'b0, a[0]});
        dy_ap = $signed({1'b0, p[1]}) - $signed({1'b0, a[1]});
        return (EW'(dx_ab) * EW'(dy_ap)) - (EW'(dy_ab) * EW'(dx_ap));
    endfunction

    function automatic logic [WOI-1:0] min3(input logic [WOI-1:0] a, b, c);
        logic [WOI-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [WOI-1:0] max3(input logic [WOI-1:0] a, b, c);
        logic [WOI-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic nonpos(input logic signed [EW-1:0] e);
        return e[EW-1] || (e == '0);
    endfunction

    logic [WOI-1:0]        xmin_c, ymin_c, xmax_raw, ymax_raw;
    logic signed [EW-1:0]  area_c, e01, e12, e20;
    logic                  covered, slot_free;
    vtx_t                  cur;

    always_comb begin
        xmin_c   = min3(v1_q[0], v2_q[0], v3_q[0]);
        ymin_c   = min3(v1_q[1], v2_q[1], v3_q[1]);
        xmax_raw = max3(v1_q[0], v2_q[0], v3_q[0]);
        ymax_raw = max3(v1_q[1], v2_q[1], v3_q[1]);
        area_c   = edge_fn(v1_q, v2_q, v3_q);
        cur      = {cy, cx};
        e01      = edge_fn(v1_q, v2_q, cur);
        e12      = edge_fn(v2_q, v3_q, cur);
        e20      = edge_fn(v3_q, v1_q, cur);
        // Inclusive edges, either winding: all three on the same side or on the line.
        covered  = (!e01[EW-1] && !e12[EW-1] && !e20[EW-1]) ||
                   (nonpos(e01) && nonpos(e12) && nonpos(e20));
        slot_free = !pix_valid || pix_ready;
    end

    assign tri_ready = (state == IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            v1_q      <= '0;
            v2_q      <= '0;
            v3_q      <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymax      <= '0;
            cx        <= '0;
            cy        <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pix_valid && pix_ready)
                pix_valid <= 1'b0;
            case (state)
                IDLE: if (tri_valid) begin
                    v1_q <= V1;
                    v2_q <= V2;
                    v3_q <= V3;
                    if (clip) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    xmin <= xmin_c;
                    xmax <= (xmax_raw > XLIM) ? XLIM : xmax_raw;
                    ymax <= (ymax_raw > YLIM) ? YLIM : ymax_raw;
                    cx   <= xmin_c;
                    cy   <= ymin_c;
                    if (area_c == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: if (slot_free) begin
                    pix_valid <= covered;
                    if (covered) begin
                        pix_x <= cx;
                        pix_y <= cy;
                    end
                    if (cx == xmax) begin
                        cx <= xmin;
                        if (cy == ymax) state <= DRAIN;
                        else            cy    <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DRAIN: if (!pix_valid) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Self-checking bench for triangle_rasterizer: table vectors, corner sequences and
// random triangles compared against a brute-force coverage model.
module tb_triangle_rasterizer;
    logic              Clk = 1'b0;
    logic              Reset;
    logic [1:0][11:0]  V1, V2, V3;
    logic              clip, tri_valid, tri_ready;
    logic [11:0]       pix_x, pix_y;
    logic              pix_valid, pix_ready, done;

    triangle_rasterizer #(.WOI(12), .SCR_W(640), .SCR_H(480)) dut (
        .Clk(Clk), .Reset(Reset), .V1(V1), .V2(V2), .V3(V3), .clip(clip),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .done(done)
    );

    always #5 Clk = ~Clk;

    typedef struct { int x; int y; } pt_t;
    typedef struct { int ax, ay, bx, by, cx, cy; bit clp; int exp_cnt; } vec_t;

    pt_t got[$];
    pt_t exp_q[$];
    int  done_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    always @(negedge Clk) begin
        if (!Reset && pix_valid && pix_ready) got.push_back('{int'(pix_x), int'(pix_y)});
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int efn(input int ax, ay, bx, by, px, py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    // Reference: every pixel of the clamped bounding box, row-major, kept if inside.
    task automatic build_model(input int ax, ay, bx, by, cx, cy, input bit clp);
        int x0, x1, y0, y1, e0, e1, e2;
        exp_q.delete();
        if (clp || efn(ax, ay, bx, by, cx, cy) == 0) return;
        x0 = ax; if (bx < x0) x0 = bx; if (cx < x0) x0 = cx;
        y0 = ay; if (by < y0) y0 = by; if (cy < y0) y0 = cy;
        x1 = ax; if (bx > x1) x1 = bx; if (cx > x1) x1 = cx;
        y1 = ay; if (by > y1) y1 = by; if (cy > y1) y1 = cy;
        if (x1 > 639) x1 = 639;
        if (y1 > 479) y1 = 479;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                e0 = efn(ax, ay, bx, by, x, y);
                e1 = efn(bx, by, cx, cy, x, y);
                e2 = efn(cx, cy, ax, ay, x, y);
                if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                    exp_q.push_back('{x, y});
            end
    endtask

    task automatic drive_tri(input int ax, ay, bx, by, cx, cy, input bit clp);
        V1[0] = 12'(ax); V1[1] = 12'(ay);
        V2[0] = 12'(bx); V2[1] = 12'(by);
        V3[0] = 12'(cx); V3[1] = 12'(cy);
        clip = clp;
        tri_valid = 1'b1;
    endtask

    task automatic scramble();
        tri_valid = 1'b0;
        V1 = 24'($urandom); V2 = 24'($urandom); V3 = 24'($urandom);
        clip = 1'($urandom);
    endtask

    // Runs one triangle from accept to done; rmode=1 randomizes pix_ready,
    // stall_at>=0 holds pix_ready low 5 cycles on that pixel, lat checks first-pixel timing.
    task automatic run_tri(input string name, input int ax, ay, bx, by, cx, cy,
                           input bit clp, input int exp_cnt, input int rmode,
                           input int stall_at, input bit lat);
        int d0, bad, n;
        bit stalled;
        int sx, sy;
        build_model(ax, ay, bx, by, cx, cy, clp);
        for (int i = 0; i < 50 && !tri_ready; i++) begin @(posedge Clk); #1; end
        chk({name, " ready before accept"}, tri_ready, 1);
        got.delete();
        d0 = done_cnt;
        stalled = 0;
        drive_tri(ax, ay, bx, by, cx, cy, clp);
        @(posedge Clk); #1;
        scramble();
        chk({name, " accepted"}, tri_ready, 0);
        for (int cyc = 1; cyc <= 3000 && done_cnt == d0; cyc++) begin
            pix_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (lat && cyc < 3) chk({name, " early pix_valid"}, pix_valid, 0);
            if (lat && cyc == 3) begin
                chk({name, " first pix_valid at t+3"}, pix_valid, 1);
                chk({name, " first pix_x"}, pix_x, 0);
                chk({name, " first pix_y"}, pix_y, 0);
            end
            if (stall_at >= 0 && !stalled && pix_valid && got.size() == stall_at) begin
                stalled = 1;
                sx = pix_x; sy = pix_y;
                chk({name, " stalled pixel x"}, sx, exp_q[stall_at].x);
                chk({name, " stalled pixel y"}, sy, exp_q[stall_at].y);
                pix_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    chk({name, " hold pix_valid"}, pix_valid, 1);
                    chk({name, " hold pix_x"}, pix_x, sx);
                    chk({name, " hold pix_y"}, pix_y, sy);
                    @(posedge Clk); #1;
                end
                pix_ready = 1'b1;
            end
            @(posedge Clk); #1;
        end
        chk({name, " done seen before timeout"}, done_cnt > d0, 1);
        pix_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk({name, " done pulses"}, done_cnt - d0, 1);
        chk({name, " pix count vs model"}, got.size(), exp_q.size());
        if (exp_cnt >= 0) chk({name, " pix count"}, got.size(), exp_cnt);
        if (stall_at >= 0) chk({name, " stall happened"}, stalled, 1);
        bad = -1;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n && bad < 0; i++)
            if (got[i].x != exp_q[i].x || got[i].y != exp_q[i].y) bad = i;
        chk({name, " first out-of-order index"}, bad, -1);
    endtask

    vec_t tbl[8];

    initial begin
        int d0, ax, ay;
        tbl[0] = '{0, 0, 4, 0, 0, 4, 1'b0, 15};
        tbl[1] = '{0, 0, 0, 4, 4, 0, 1'b0, 15};
        tbl[2] = '{0, 0, 2, 2, 4, 4, 1'b0, 0};
        tbl[3] = '{5, 5, 5, 5, 5, 5, 1'b0, 0};
        tbl[4] = '{0, 0, 3, 0, 0, 3, 1'b0, 10};
        tbl[5] = '{2, 1, 6, 1, 2, 5, 1'b0, 15};
        tbl[6] = '{630, 470, 639, 470, 639, 479, 1'b0, 55};
        tbl[7] = '{10, 10, 20, 20, 5, 30, 1'b1, 0};

        Reset = 1'b1; tri_valid = 1'b0; clip = 1'b0; pix_ready = 1'b1;
        V1 = '0; V2 = '0; V3 = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset tri_ready", tri_ready, 1);
        chk("reset pix_valid", pix_valid, 0);
        chk("reset done", done, 0);
        chk("reset pix_x", pix_x, 0);
        chk("reset pix_y", pix_y, 0);
        Reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_tri($sformatf("tbl%0d", i), tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by,
                    tbl[i].cx, tbl[i].cy, tbl[i].clp, tbl[i].exp_cnt, 0, -1, i == 0);

        // clip latency: done only at t+1, ready again at t+2
        d0 = done_cnt;
        drive_tri(1, 1, 9, 1, 1, 9, 1'b1);
        @(posedge Clk); #1;
        scramble();
        @(negedge Clk);
        chk("clip done at t+1", done, 1);
        chk("clip tri_ready at t+1", tri_ready, 0);
        chk("clip pix_valid at t+1", pix_valid, 0);
        @(negedge Clk);
        chk("clip done cleared at t+2", done, 0);
        chk("clip tri_ready at t+2", tri_ready, 1);
        chk("clip done count", done_cnt - d0, 1);
        @(posedge Clk); #1;

        run_tri("stall", 0, 0, 4, 0, 0, 4, 1'b0, 15, 0, 2, 1'b0);

        // reset after the 4th pixel: in-flight pixel dropped, no done, immediate re-accept
        got.delete();
        d0 = done_cnt;
        drive_tri(0, 0, 4, 0, 0, 4, 1'b0);
        @(posedge Clk); #1;
        scramble();
        for (int i = 0; i < 100 && got.size() < 4; i++) begin @(posedge Clk); #1; end
        chk("pre-reset pixels", got.size(), 4);
        Reset = 1'b1; pix_ready = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0; pix_ready = 1'b1;
        chk("post-reset pix_valid", pix_valid, 0);
        chk("post-reset tri_ready", tri_ready, 1);
        run_tri("after reset", 0, 0, 4, 0, 0, 4, 1'b0, 15, 0, -1, 1'b1);
        chk("no done from aborted triangle", done_cnt - d0, 1);

        for (int r = 0; r < 20; r++) begin
            ax = $urandom_range(0, 600);
            ay = $urandom_range(0, 450);
            run_tri($sformatf("rand%0d", r),
                    ax + $urandom_range(0, 15), ay + $urandom_range(0, 15),
                    ax + $urandom_range(0, 15), ay + $urandom_range(0, 15),
                    ax + $urandom_range(0, 15), ay + $urandom_range(0, 15),
                    ($urandom_range(0, 5) == 0), -1, 1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
